// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed N-digit 7-segment driver with per-frame capture, LZB and blink.
// Define SEG_HEX_EN to show hex glyphs for codes A-F; otherwise those codes leave segments a-g dark.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_DIV      = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lzb,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [7:0]              SEG_DATA,
   output logic [NUM_DIGITS-1:0]   DIG_SEL,
   output logic                    frame_start
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

   function automatic logic [7:0] glyph(input logic [3:0] c);
      case (c)
         4'h0: glyph = 8'hFC;
         4'h1: glyph = 8'h60;
         4'h2: glyph = 8'hDA;
         4'h3: glyph = 8'hF2;
         4'h4: glyph = 8'h66;
         4'h5: glyph = 8'hB6;
         4'h6: glyph = 8'hBE;
         4'h7: glyph = 8'hE0;
         4'h8: glyph = 8'hFE;
         4'h9: glyph = 8'hF6;
`ifdef SEG_HEX_EN
         4'hA: glyph = 8'hEE;
         4'hB: glyph = 8'h3E;
         4'hC: glyph = 8'h9C;
         4'hD: glyph = 8'h7A;
         4'hE: glyph = 8'h9E;
         4'hF: glyph = 8'h8E;
`endif
         default: glyph = 8'h00;
      endcase
   endfunction

   logic [DW-1:0]           div_q, div_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
   logic [NUM_DIGITS-1:0]   dpf_q, dpf_d;
   logic [FW-1:0]           fcnt_q, fcnt_d;
   logic                    run_q, run_d;
   logic                    phase_q, phase_d;
   logic [7:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   dig_q, dig_d;
   logic                    fs_q, fs_d;
   logic                    tick, wrap, flip, zr, blank, hide, dpb;
   logic [NUM_DIGITS-1:0]   lz_v;
   logic [3:0]              code;
   logic [7:0]              dec;

   // The wrap that opens the very first frame completes no frame, hence run_q gating the blink count.
   always_comb begin
      tick    = div_q == DW'(CLK_DIV - 1);
      wrap    = tick && idx_q == IW'(NUM_DIGITS - 1);
      flip    = en && wrap && run_q && fcnt_q == FW'(BLINK_FRAMES - 1);
      div_d   = (!en || tick) ? '0 : div_q + 1'b1;
      idx_d   = !en ? IW'(NUM_DIGITS - 1) : !tick ? idx_q : wrap ? '0 : idx_q + 1'b1;
      bcd_d   = (en && wrap) ? bcd_in : bcd_q;
      dpf_d   = (en && wrap) ? dp_in : dpf_q;
      fcnt_d  = !en ? '0 : !(wrap && run_q) ? fcnt_q : flip ? '0 : fcnt_q + 1'b1;
      run_d   = en && (run_q || wrap);
      phase_d = en && (phase_q ^ flip);
      fs_d    = en && wrap;
      zr      = 1'b1;
      lz_v    = '0;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         zr      = zr & (bcd_d[4*k +: 4] == 4'd0);
         lz_v[k] = zr;
      end
      code    = bcd_d[4*idx_d +: 4];
      dpb     = dpf_d[idx_d];
      dec     = glyph(code);
      blank   = lzb && lz_v[idx_d];
      hide    = phase_d && blink_mask[idx_d];
      seg_d   = !en ? 8'h00 : !tick ? seg_q : hide ? 8'h00 : {blank ? 7'h00 : dec[7:1], dec[0] | dpb};
      dig_d   = !en ? '0 : tick ? {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d : dig_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q   <= '0;
         idx_q   <= IW'(NUM_DIGITS - 1);
         bcd_q   <= '0;
         dpf_q   <= '0;
         fcnt_q  <= '0;
         run_q   <= 1'b0;
         phase_q <= 1'b0;
         seg_q   <= '0;
         dig_q   <= '0;
         fs_q    <= 1'b0;
      end else begin
         div_q   <= div_d;
         idx_q   <= idx_d;
         bcd_q   <= bcd_d;
         dpf_q   <= dpf_d;
         fcnt_q  <= fcnt_d;
         run_q   <= run_d;
         phase_q <= phase_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
         fs_q    <= fs_d;
      end
   end

   assign SEG_DATA    = seg_q;
   assign DIG_SEL     = dig_q;
   assign frame_start = fs_q;
endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Parametrised, time-multiplexed driver for an N-digit common-segment 7-segment display. It captures a packed BCD word once per scan frame and scans one digit at a time at a programmable rate. Each digit is decoded to the a–g/dp segment pattern, with leading-zero blanking, per-digit blink and a global enable. It sits between the timer datapath, which supplies BCD digits, and the board display pins.

## Interface
- `NUM_DIGITS`, 4: number of digits; legal range 2..8.
- `CLK_DIV`, 50000: clocks per digit slot; must be at least 2.
- `BLINK_FRAMES`, 64: frames per blink half-period; must be at least 1.

- `clk` input 1: system clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: display enable.
- `bcd_in` input 4*NUM_DIGITS: packed digits; digit i is `bcd_in[4i+3:4i]`; digit 0 is the rightmost, least significant digit.
- `dp_in` input NUM_DIGITS: decimal point per digit.
- `lzb` input 1: leading-zero blanking enable.
- `blink_mask` input NUM_DIGITS: digits that blink.
- `SEG_DATA` output 8: segment pattern, active high; bit7=a, bit6=b, … bit1=g, bit0=dp.
- `DIG_SEL` output NUM_DIGITS: digit enable, one-hot, active high.
- `frame_start` output 1: one-cycle pulse after each frame capture.

## Operation
- **Prescaler `div_cnt`**
  - Counts 0..CLK_DIV-1.
  - A tick occurs on the edge where `div_cnt`==CLK_DIV-1; on that edge `div_cnt` returns to 0.
- **Digit index `idx`**
  - Advances on each tick: 0,1,…,NUM_DIGITS-1, then wraps to 0.
  - Reset value is NUM_DIGITS-1, so the first tick starts a frame.
- **Frame capture**
  - On the tick where `idx` wraps to 0, `bcd_in`/`dp_in` are latched into the frame register.
  - Digit 0 of that frame uses the newly latched value.
  - Input changes mid-frame are not visible until the next wrap; a frame never mixes old and new values.
- **Decode**
  - 0–9 map to FC,60,DA,F2,66,B6,BE,E0,FE,F6 (hex). Bit0 is then OR'd with the digit's dp bit.
  - Codes A–F: see Configuration.
- **Leading-zero blanking** (`lzb`=1), evaluated on the frame register:
  - A digit k≥1 is blanked when it and every digit above it is 0.
  - Digit 0 is never blanked.
  - Blanked digits output segments a–g = 0, but dp still follows `dp_in`.
- **Blink**
  - A frame counter counts completed frames; `blink_phase` toggles every BLINK_FRAMES frames.
  - When `blink_phase`=1, digits with `blink_mask`=1 output SEG_DATA=00 (dp included).
  - `blink_phase` resets to 0 (visible).
- **Enable**
  - On any edge with `en`=0: `SEG_DATA`=00, `DIG_SEL`=0, `frame_start`=0; `div_cnt`, `idx`, frame counter and `blink_phase` return to their reset values.
  - Re-asserting `en` starts a fresh frame.

## Timing
- **Reset values:** `SEG_DATA`=00, `DIG_SEL`=0, `frame_start`=0, `div_cnt`=0, `idx`=NUM_DIGITS-1, frame register 0, `blink_phase`=0.
- **Registered outputs:** `SEG_DATA` and `DIG_SEL` update on the tick edge, together with `idx`. They hold constant for CLK_DIV cycles.
- **First digit:** after reset release with `en`=1, the first non-zero `DIG_SEL` (digit 0) appears after CLK_DIV rising edges.
- **`frame_start`:** high for exactly the one cycle following the capture edge.
- **`rst` mid-frame:** outputs are cleared immediately (asynchronously). Recovery behaves exactly as after power-up reset.
- **Simultaneous events:** `en` falling on a tick edge means disable wins; no capture and no `frame_start`.
- **Blink vs. blanking:** blink and leading-zero blanking combine by OR, i.e. blank if either applies.

## Configuration
- **`SEG_HEX_EN` defined:** codes A–F decode to EE,3E,9C,7A,9E,8E, giving glyphs A,b,C,d,E,F.
- **`SEG_HEX_EN` undefined:** codes A–F decode to 00 (a–g off); the dp bit still applies.
- **Leading-zero blanking:** in both builds, the zero test uses the code value 0 only.

## Test plan
Bench uses NUM_DIGITS=4, CLK_DIV=4, BLINK_FRAMES=2, `en`=1, `lzb`=0.

- **Basic scan:** release `rst`, `bcd_in`=16'h1234 -> edges 4/8/12/16 show DIG_SEL 0001/0010/0100/1000 with SEG 66/F2/DA/60; `frame_start` high during cycle 5 only.
- **No tearing:** change `bcd_in` to 16'h9876 while digit 1 is displayed -> digits 2 and 3 still show DA and 60; the next frame shows F6-derived values starting with digit0=BE.
- **Leading-zero blanking:** `lzb`=1, `bcd_in`=16'h0050 -> digits 3 and 2 show 00, digit 1 shows B6, digit 0 shows FC. Then `bcd_in`=0 -> only digit 0 shows FC. `dp_in`=4'b1000 with `bcd_in`=0 -> digit 3 shows 01.
- **Invalid code and dp:** digit 0 code 4'hA -> 00 without `SEG_HEX_EN`, EE with it. Digit code 1 with its dp bit set -> 61.
- **Blink:** `blink_mask`=4'b0001 -> digit 0 shows its pattern in frames 0–1, 00 in frames 2–3, its pattern again in frames 4–5; unmasked digits are unaffected.
- **Disable and reset mid-frame:** drop `en` during digit 2 -> 00 and DIG_SEL=0 on the next edge; re-enable -> digit 0 appears 4 edges later. Assert `rst` during digit 1 -> outputs 0 immediately, with no clock edge needed.
